// File: rtl/fifo_line_reader_if.sv
// Handshake bundle between the line reader, its prefetch FIFO read port and
// the downstream pixel consumer.
interface fifo_line_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic                  fifo_rd_vld;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_sof;
  logic                  o_sol;
  logic                  o_eol;
  logic                  o_eof;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_vld,
    input  fifo_rd_data,
    output o_valid,
    input  o_ready,
    output o_data,
    output o_sof,
    output o_sol,
    output o_eol,
    output o_eof
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_vld,
    output fifo_rd_data,
    input  o_valid,
    output o_ready,
    input  o_data,
    input  o_sof,
    input  o_sol,
    input  o_eol,
    input  o_eof
  );
endinterface

// File: rtl/fifo_line_reader.sv
// Pops pixels from a first-word-fall-through FIFO and emits them as framed
// lines (sof/sol/eol/eof) with idle blanking cycles between lines.
module fifo_line_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int H_BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  fifo_line_reader_if.master    bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           underflow_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK
  } state_t;

  localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] B_LAST = 12'(H_BLANK - 1);

  state_t                state;
  state_t                state_nxt;
  logic [11:0]           x_cnt;
  logic [11:0]           y_cnt;
  logic [11:0]           blank_cnt;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  sof_q;
  logic                  sol_q;
  logic                  eol_q;
  logic                  eof_q;
  logic                  can_take;
  logic                  pop;
  logic                  x_last;
  logic                  y_last;

  // The output register can take a new word when empty or being drained.
  assign can_take       = ~valid_q | bus.o_ready;
  assign pop            = (state == ACTIVE) & bus.fifo_rd_vld & can_take;
  assign x_last         = (x_cnt == X_LAST);
  assign y_last         = (y_cnt == Y_LAST);
  assign bus.fifo_rd_en = pop;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_sof      = sof_q;
  assign bus.o_sol      = sol_q;
  assign bus.o_eol      = eol_q;
  assign bus.o_eof      = eof_q;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pop && x_last) begin
          if (y_last) begin
            state_nxt = IDLE;
          end else if (H_BLANK > 0) begin
            state_nxt = HBLANK;
          end
        end
      end
      HBLANK: begin
        if (blank_cnt == B_LAST) begin
          state_nxt = ACTIVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel position within the frame advances on every pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == IDLE && start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pop) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? 12'd0 : y_cnt + 12'd1;
      end else begin
        x_cnt <= x_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= '0;
    end else if (state == HBLANK && state_nxt == HBLANK) begin
      blank_cnt <= blank_cnt + 12'd1;
    end else begin
      blank_cnt <= '0;
    end
  end

  // Flags are captured alongside the popped word so they stay aligned under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      sol_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (pop) begin
      valid_q <= 1'b1;
      data_q  <= bus.fifo_rd_data;
      sol_q   <= (x_cnt == 12'd0);
      eol_q   <= x_last;
      sof_q   <= (x_cnt == 12'd0) && (y_cnt == 12'd0);
      eof_q   <= x_last && y_last;
    end else if (valid_q && bus.o_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop & x_last & y_last;
    end
  end

  // A starved cycle is one where a word could have been taken but none was there.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (state == ACTIVE && !bus.fifo_rd_vld && can_take &&
                 underflow_cnt != 16'hFFFF) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_line_reader.sv
// Directed bench for fifo_line_reader on a 4x2 frame with 2 blanking cycles;
// a FIFO model feeds the DUT and a scoreboard checks every accepted pixel.
module tb_fifo_line_reader;

  localparam int DW = 16;
  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HB = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [15:0] underflow_cnt;

  fifo_line_reader_if #(.DATA_WIDTH(DW)) ifc ();

  fifo_line_reader #(
    .DATA_WIDTH(DW),
    .H_ACTIVE  (HA),
    .V_ACTIVE  (VA),
    .H_BLANK   (HB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (ifc),
    .busy         (busy),
    .frame_done   (frame_done),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          flush = 1'b0;

  assign ifc.fifo_rd_vld  = (wr_ptr != rd_ptr);
  assign ifc.fifo_rd_data = fifo_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (ifc.fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  exp_t expq[$];
  int   accept_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Load words into the FIFO model and queue the pixels they should become.
  task automatic applyStimulus(input int first, input int count, input int idx0);
    for (int i = 0; i < count; i++) begin
      int   k;
      int   x;
      int   y;
      exp_t e;
      k = (idx0 + i) % (HA * VA);
      x = k % HA;
      y = k / HA;
      fifo_mem[wr_ptr[5:0]] = DW'(first + i);
      wr_ptr++;
      e.data  = DW'(first + i);
      e.flags = {(x == 0) && (y == 0), x == 0, x == HA - 1, (x == HA - 1) && (y == VA - 1)};
      expq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitFrameDone(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 200) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(frame_done), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && ifc.o_valid && ifc.o_ready) begin
      accept_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        checkOutput("extra_pixel", 32'(ifc.o_data), 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        checkOutput("pix_data", 32'(ifc.o_data), 32'(e.data));
        checkOutput("pix_flags", 32'({ifc.o_sof, ifc.o_sol, ifc.o_eol, ifc.o_eof}), 32'(e.flags));
      end
    end
  end

  initial begin
    int n;
    int fd;
    logic [15:0] u0;

    rst         = 1'b1;
    start       = 1'b0;
    ifc.o_ready = 1'b1;
    applyStimulus(1, 8, 0);
    repeat (3) tick();
    checkOutput("rst_valid", 32'(ifc.o_valid), 32'd0);
    checkOutput("rst_data", 32'(ifc.o_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_uflow", 32'(underflow_cnt), 32'd0);
    checkOutput("rst_rd_en", 32'(ifc.fifo_rd_en), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_rd_en", 32'(ifc.fifo_rd_en), 32'd0);

    $display("[TB] basic frame");
    accept_cyc.delete();
    pulseStart();
    waitFrameDone("f1_done");
    checkOutput("f1_last_data", 32'(ifc.o_data), 32'd8);
    tick();
    checkOutput("f1_done_pulse", 32'(frame_done), 32'd0);
    checkOutput("f1_busy", 32'(busy), 32'd0);
    checkOutput("f1_drained", 32'(expq.size()), 32'd0);
    checkOutput("f1_count", 32'(accept_cyc.size()), 32'd8);
    if (accept_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++) begin
        checkOutput($sformatf("f1_gap_%0d", i), 32'(accept_cyc[i] - accept_cyc[i-1]),
                    (i == 4) ? 32'd3 : 32'd1);
      end
    end
    checkOutput("f1_uflow", 32'(underflow_cnt), 32'd0);

    $display("[TB] downstream stall");
    applyStimulus(1, 8, 0);
    pulseStart();
    n = 0;
    while (!ifc.o_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("stall_first_valid", 32'(ifc.o_valid), 32'd1);
    ifc.o_ready = 1'b0;
    u0 = underflow_cnt;
    repeat (5) begin
      tick();
      checkOutput("stall_valid", 32'(ifc.o_valid), 32'd1);
      checkOutput("stall_data", 32'(ifc.o_data), 32'd1);
      checkOutput("stall_rd_en", 32'(ifc.fifo_rd_en), 32'd0);
      checkOutput("stall_uflow", 32'(underflow_cnt), 32'(u0));
    end
    ifc.o_ready = 1'b1;
    waitFrameDone("stall_done");
    tick();
    checkOutput("stall_uflow_end", 32'(underflow_cnt), 32'd0);
    checkOutput("stall_drained", 32'(expq.size()), 32'd0);

    $display("[TB] FIFO starvation");
    applyStimulus(1, 2, 0);
    pulseStart();
    n = 0;
    while (underflow_cnt != 16'd3 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("starve_cnt", 32'(underflow_cnt), 32'd3);
    applyStimulus(3, 6, 2);
    waitFrameDone("starve_done");
    tick();
    checkOutput("starve_uflow_end", 32'(underflow_cnt), 32'd3);
    checkOutput("starve_drained", 32'(expq.size()), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 8, 0);
    pulseStart();
    n = 0;
    while (!(ifc.o_valid && ifc.o_data == 16'd3) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("mid_pixel3", 32'(ifc.o_data), 32'd3);
    rst = 1'b1;
    tick();
    expq.delete();
    checkOutput("mid_valid", 32'(ifc.o_valid), 32'd0);
    checkOutput("mid_data", 32'(ifc.o_data), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_uflow", 32'(underflow_cnt), 32'd0);
    checkOutput("mid_rd_en", 32'(ifc.fifo_rd_en), 32'd0);
    checkOutput("mid_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("mid_fifo_has_data", 32'(ifc.fifo_rd_vld), 32'd1);
    checkOutput("mid_rd_en_after", 32'(ifc.fifo_rd_en), 32'd0);
    checkOutput("mid_busy_after", 32'(busy), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    $display("[TB] back-to-back frames");
    applyStimulus(1, 16, 0);
    start = 1'b1;
    fd = 0;
    n = 0;
    while (fd < 2 && n < 200) begin
      tick();
      n++;
      if (frame_done) begin
        fd++;
        if (fd == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("b2b_done_count", 32'(fd), 32'd2);
    repeat (2) tick();
    checkOutput("b2b_busy", 32'(busy), 32'd0);
    checkOutput("b2b_drained", 32'(expq.size()), 32'd0);
    checkOutput("b2b_uflow", 32'(underflow_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
